pipelined_adder: RTL

Parametrised, pipelined ripple-carry adder/subtractor. The WIDTH-bit operands are split into STAGES equal slices, and one slice is added per clock, with carry registered between slices. This gives full throughput at WIDTH bits without a WIDTH-long combinational carry chain. It sits in the datapath wherever the fixed 4-bit adder is too narrow or too slow, and uses a valid/ready stream on both sides.

---
 rtl/pipelined_adder.sv | 94 +++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one SLICE-bit carry slice per stage, carry registered between slices.
// Latency STAGES cycles from accepted beat to out_valid; one beat per clock when not stalled.
// A held output (out_valid && !out_ready) freezes every stage and drops in_ready; bubbles are not squeezed out.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Operands travel with the beat; res fills in from the LSB slice upward as stages complete.
    typedef struct packed {
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } stage_t;

    stage_t            src       [STAGES];
    stage_t            pipe_d    [STAGES];
    stage_t            pipe_q    [STAGES];
    logic [SLICE:0]    slice_sum [STAGES];
    logic [STAGES-1:0] vld_q;
    logic              advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = pipe_q[STAGES-1].res;
    assign cout      = pipe_q[STAGES-1].carry;
    assign ovf       = pipe_q[STAGES-1].ovf;

    always_comb begin
        src[0].opa   = a;
        src[0].opb   = sub ? ~b : b;
        src[0].res   = '0;
        src[0].carry = cin ^ sub;
        src[0].ovf   = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = pipe_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, src[k].opa[k*SLICE +: SLICE]}
                         + {1'b0, src[k].opb[k*SLICE +: SLICE]}
                         + {{SLICE{1'b0}}, src[k].carry};
            pipe_d[k]                        = src[k];
            pipe_d[k].res[k*SLICE +: SLICE]  = slice_sum[k][SLICE-1:0];
            pipe_d[k].carry                  = slice_sum[k][SLICE];
            // Carry into the MSB is a^b^s at that bit; only the last stage's value is ever observed.
            pipe_d[k].ovf = slice_sum[k][SLICE] ^ src[k].opa[WIDTH-1]
                          ^ src[k].opb[WIDTH-1] ^ slice_sum[k][SLICE-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                pipe_q[0] <= pipe_d[0];
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    pipe_q[k] <= pipe_d[k];
                end
            end
        end
    end

endmodule
